// File: rtl/mips_pkg.sv
// Shared MIPS core definitions used by the multiply/divide unit:
// data width, MDU operation codes, MDU FSM states and operand helpers.
package mips_pkg;

   localparam int DATA_WIDTH = 32;
   localparam int CNT_WIDTH  = 5;

   typedef enum logic [1:0] {
      MDU_MULT  = 2'b00,
      MDU_MULTU = 2'b01,
      MDU_DIV   = 2'b10,
      MDU_DIVU  = 2'b11
   } mdu_op_e;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      CALC = 2'b01,
      FIX  = 2'b10
   } mdu_state_e;

   function automatic logic is_signed_op(input mdu_op_e op);
      return (op == MDU_MULT) || (op == MDU_DIV);
   endfunction

   function automatic logic is_div_op(input mdu_op_e op);
      return op[1];
   endfunction

   // Absolute value for signed ops; unsigned operands pass through untouched.
   function automatic logic [DATA_WIDTH-1:0] magnitude(input logic [DATA_WIDTH-1:0] v,
                                                       input logic                  signed_op);
      return (signed_op && v[DATA_WIDTH-1]) ? -v : v;
   endfunction

endpackage

// File: rtl/mult_div_unit_if.sv
// Execute-stage <-> multiply/divide unit bundle: command, operands, MT writes and HI/LO/status.
interface mult_div_unit_if #(
   parameter int DATA_WIDTH = mips_pkg::DATA_WIDTH
);
   logic                  i_StartE;
   logic [1:0]            i_MduOpE;
   logic [DATA_WIDTH-1:0] i_SrcAE;
   logic [DATA_WIDTH-1:0] i_SrcBE;
   logic                  i_MTHIE;
   logic                  i_MTLOE;
   logic [DATA_WIDTH-1:0] o_HI;
   logic [DATA_WIDTH-1:0] o_LO;
   logic                  o_Busy;
   logic                  o_Done;

   modport master (
      output i_StartE, i_MduOpE, i_SrcAE, i_SrcBE, i_MTHIE, i_MTLOE,
      input  o_HI, o_LO, o_Busy, o_Done
   );

   modport slave (
      input  i_StartE, i_MduOpE, i_SrcAE, i_SrcBE, i_MTHIE, i_MTLOE,
      output o_HI, o_LO, o_Busy, o_Done
   );
endinterface

// File: rtl/mdu_div_core.sv
// Restoring-divide datapath: unsigned magnitudes in, one quotient bit per enabled cycle,
// quotient/remainder valid after DATA_WIDTH enables.
module mdu_div_core #(
   parameter int DATA_WIDTH = mips_pkg::DATA_WIDTH
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  load,
   input  logic                  en,
   input  logic [DATA_WIDTH-1:0] dividend,
   input  logic [DATA_WIDTH-1:0] divisor,
   output logic [DATA_WIDTH-1:0] quotient,
   output logic [DATA_WIDTH-1:0] remainder
);

   logic [DATA_WIDTH-1:0] rem_q, quo_q, div_q, rem_next;
   logic [DATA_WIDTH:0]   shifted;
   logic                  fits;

   // Partial remainder shifted left with the next dividend bit; subtract only when it fits.
   assign shifted  = {rem_q, quo_q[DATA_WIDTH-1]};
   assign fits     = (shifted >= {1'b0, div_q});
   assign rem_next = fits ? DATA_WIDTH'(shifted - {1'b0, div_q}) : shifted[DATA_WIDTH-1:0];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rem_q <= '0;
         quo_q <= '0;
         div_q <= '0;
      end else if (load) begin
         rem_q <= '0;
         quo_q <= dividend;
         div_q <= divisor;
      end else if (en) begin
         rem_q <= rem_next;
         quo_q <= {quo_q[DATA_WIDTH-2:0], fits};
      end
   end

   assign quotient  = quo_q;
   assign remainder = rem_q;

endmodule

// File: rtl/mult_div_unit.sv
// Iterative MIPS multiply/divide unit with architectural HI/LO, MTHI/MTLO and a busy stall flag.
// Build option MDU_FAST_MULT_EN: single-cycle combinational multiply; divide stays iterative.
module mult_div_unit #(
   parameter int DATA_WIDTH = mips_pkg::DATA_WIDTH,
   parameter int CNT_WIDTH  = mips_pkg::CNT_WIDTH
) (
   input logic            i_CLK,
   input logic            i_RST,
   mult_div_unit_if.slave bus
);
   import mips_pkg::*;

   localparam logic [CNT_WIDTH-1:0] LAST_ITER = CNT_WIDTH'(DATA_WIDTH - 1);

   mdu_state_e              state_q, state_d;
   mdu_op_e                 op_in, op_q;
   logic                    signed_in, launch, calc, fix, mt_ok;
   logic [DATA_WIDTH-1:0]   mag_a_in, mag_b_in;
   logic [DATA_WIDTH-1:0]   a_raw_q, mag_a_q, mag_b_q;
   logic                    neg_q, rem_neg_q, div0_q, busy_q, done_q;
   logic [CNT_WIDTH-1:0]    cnt_q;
   logic [DATA_WIDTH-1:0]   hi_q, lo_q, res_hi, res_lo, quotient, remainder;
   logic [2*DATA_WIDTH-1:0] product, product_s;

   assign op_in     = mdu_op_e'(bus.i_MduOpE);
   assign signed_in = is_signed_op(op_in);
   assign mag_a_in  = magnitude(bus.i_SrcAE, signed_in);
   assign mag_b_in  = magnitude(bus.i_SrcBE, signed_in);

   always_ff @(posedge i_CLK or posedge i_RST) begin
      if (i_RST) state_q <= IDLE;
      else       state_q <= state_d;
   end

   always_comb begin
      // NOTE: every combinational output gets a default first so no path can infer a latch.
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (bus.i_StartE) begin
`ifdef MDU_FAST_MULT_EN
               state_d = is_div_op(op_in) ? CALC : FIX;
`else
               state_d = CALC;
`endif
            end
         end
         CALC:    if (cnt_q == LAST_ITER) state_d = FIX;
         FIX:     state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      launch = 1'b0;
      calc   = 1'b0;
      fix    = 1'b0;
      mt_ok  = 1'b0;
      case (state_q)
         IDLE: begin
            launch = bus.i_StartE;
            mt_ok  = !bus.i_StartE;
         end
         CALC:    calc = 1'b1;
         FIX:     fix  = 1'b1;
         default: ;
      endcase
   end

   mdu_div_core #(.DATA_WIDTH(DATA_WIDTH)) u_div_core (
      .clk       (i_CLK),
      .rst       (i_RST),
      .load      (launch),
      .en        (calc && is_div_op(op_q)),
      .dividend  (mag_a_in),
      .divisor   (mag_b_in),
      .quotient  (quotient),
      .remainder (remainder)
   );

`ifdef MDU_FAST_MULT_EN
   assign product = (2*DATA_WIDTH)'(mag_a_q) * (2*DATA_WIDTH)'(mag_b_q);
`else
   logic [2*DATA_WIDTH-1:0] acc_q;
   logic [DATA_WIDTH:0]     acc_sum;

   // Shift-add: add the multiplicand into the upper half for multiplier bit cnt, then shift right.
   assign acc_sum = {1'b0, acc_q[2*DATA_WIDTH-1:DATA_WIDTH]}
                  + (mag_b_q[cnt_q] ? {1'b0, mag_a_q} : '0);

   always_ff @(posedge i_CLK or posedge i_RST) begin
      if (i_RST)                          acc_q <= '0;
      else if (launch)                    acc_q <= '0;
      else if (calc && !is_div_op(op_q))  acc_q <= {acc_sum, acc_q[DATA_WIDTH-1:1]};
   end

   assign product = acc_q;
`endif

   always_comb begin
      product_s = neg_q ? -product : product;
      res_hi    = product_s[2*DATA_WIDTH-1:DATA_WIDTH];
      res_lo    = product_s[DATA_WIDTH-1:0];
      if (is_div_op(op_q)) begin
         if (div0_q) begin
            res_hi = a_raw_q;
            res_lo = '1;
         end else begin
            res_hi = rem_neg_q ? -remainder : remainder;
            res_lo = neg_q ? -quotient : quotient;
         end
      end
   end

   always_ff @(posedge i_CLK or posedge i_RST) begin
      if (i_RST) begin
         op_q      <= MDU_MULT;
         a_raw_q   <= '0;
         mag_a_q   <= '0;
         mag_b_q   <= '0;
         neg_q     <= 1'b0;
         rem_neg_q <= 1'b0;
         div0_q    <= 1'b0;
         cnt_q     <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         hi_q      <= '0;
         lo_q      <= '0;
      end else begin
         // NOTE: state updates use non-blocking assignment so every flop samples pre-edge values.
         busy_q <= (state_d != IDLE);
         done_q <= fix;
         if (launch) begin
            op_q      <= op_in;
            a_raw_q   <= bus.i_SrcAE;
            mag_a_q   <= mag_a_in;
            mag_b_q   <= mag_b_in;
            neg_q     <= signed_in && (bus.i_SrcAE[DATA_WIDTH-1] ^ bus.i_SrcBE[DATA_WIDTH-1]);
            rem_neg_q <= signed_in && bus.i_SrcAE[DATA_WIDTH-1];
            div0_q    <= (bus.i_SrcBE == '0);
            cnt_q     <= '0;
         end else if (calc) begin
            cnt_q <= cnt_q + CNT_WIDTH'(1);
         end
         // HI/LO change only as a whole result in FIX, or by an MT write while idle and not starting.
         if (fix) begin
            hi_q <= res_hi;
            lo_q <= res_lo;
         end else if (mt_ok) begin
            if (bus.i_MTHIE) hi_q <= bus.i_SrcAE;
            if (bus.i_MTLOE) lo_q <= bus.i_SrcAE;
         end
      end
   end

   assign bus.o_HI   = hi_q;
   assign bus.o_LO   = lo_q;
   assign bus.o_Busy = busy_q;
   assign bus.o_Done = done_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: directed corner cases plus randomized ops
// compared against a plain-arithmetic reference model.
module tb_mult_div_unit;
   import mips_pkg::*;

`ifdef MDU_FAST_MULT_EN
   localparam int MUL_LAT = 1;
`else
   localparam int MUL_LAT = 33;
`endif
   localparam int DIV_LAT = 33;

   logic clk = 1'b0;
   logic rst;
   int   n_cmp = 0;
   int   n_err = 0;

   mult_div_unit_if #(.DATA_WIDTH(32)) bus ();

   mult_div_unit dut (
      .i_CLK (clk),
      .i_RST (rst),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp)
      else begin
         n_err++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Architectural result of one MDU instruction, straight from the ISA rules.
   function automatic void ref_model(input mdu_op_e op, input logic [31:0] a, input logic [31:0] b,
                                     output logic [31:0] hi, output logic [31:0] lo);
      longint     sp;
      logic [63:0] up;
      int         sa, sb;
      sa = $signed(a);
      sb = $signed(b);
      hi = '0;
      lo = '0;
      case (op)
         MDU_MULT: begin
            sp = longint'(sa) * longint'(sb);
            {hi, lo} = sp;
         end
         MDU_MULTU: begin
            up = {32'b0, a} * {32'b0, b};
            {hi, lo} = up;
         end
         default: begin
            if (b == 32'd0) begin
               lo = 32'hFFFF_FFFF;
               hi = a;
            end else if (op == MDU_DIVU) begin
               lo = a / b;
               hi = a % b;
            end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
               lo = 32'h8000_0000;
               hi = 32'd0;
            end else begin
               lo = 32'(sa / sb);
               hi = 32'(sa % sb);
            end
         end
      endcase
   endfunction

   task automatic run_op(input mdu_op_e op, input logic [31:0] a, input logic [31:0] b,
                         input bit mt_with_start, input bit mthi_busy, input string tag);
      logic [31:0] exp_hi, exp_lo, prev_hi, prev_lo;
      int          busy_cycles;
      bit          held, got_done;
      ref_model(op, a, b, exp_hi, exp_lo);
      prev_hi = bus.o_HI;
      prev_lo = bus.o_LO;
      @(negedge clk);
      bus.i_StartE = 1'b1;
      bus.i_MduOpE = op;
      bus.i_SrcAE  = a;
      bus.i_SrcBE  = b;
      bus.i_MTHIE  = mt_with_start;
      bus.i_MTLOE  = mt_with_start;
      @(negedge clk);
      bus.i_StartE = 1'b0;
      bus.i_MTHIE  = 1'b0;
      bus.i_MTLOE  = 1'b0;
      bus.i_SrcAE  = $urandom;
      bus.i_SrcBE  = $urandom;
      busy_cycles  = 0;
      held         = 1'b1;
      got_done     = 1'b0;
      for (int i = 0; i < 100 && !got_done; i++) begin
         if (bus.o_Done) begin
            got_done = 1'b1;
         end else begin
            if (bus.o_Busy) busy_cycles++;
            if (bus.o_HI !== prev_hi || bus.o_LO !== prev_lo) held = 1'b0;
            bus.i_MTHIE = mthi_busy && (i == 0);
            if (mthi_busy && i == 0) bus.i_SrcAE = 32'hA5A5_A5A5;
            @(negedge clk);
         end
      end
      bus.i_MTHIE = 1'b0;
      check({tag, "_done_seen"}, 64'(got_done), 64'd1);
      check({tag, "_hi"}, 64'(bus.o_HI), 64'(exp_hi));
      check({tag, "_lo"}, 64'(bus.o_LO), 64'(exp_lo));
      check({tag, "_busy_cycles"}, 64'(busy_cycles), 64'(is_div_op(op) ? DIV_LAT : MUL_LAT));
      check({tag, "_busy_low_at_done"}, 64'(bus.o_Busy), 64'd0);
      if (mthi_busy || mt_with_start || !is_div_op(op) && MUL_LAT > 1 || is_div_op(op))
         check({tag, "_hilo_held"}, 64'(held), 64'd1);
      @(negedge clk);
      check({tag, "_done_single_pulse"}, 64'(bus.o_Done), 64'd0);
   endtask

   initial begin
      logic [31:0] prev_hi, ra, rb;
      mdu_op_e     rop;

      rst          = 1'b1;
      bus.i_StartE = 1'b0;
      bus.i_MduOpE = 2'b00;
      bus.i_SrcAE  = '0;
      bus.i_SrcBE  = '0;
      bus.i_MTHIE  = 1'b0;
      bus.i_MTLOE  = 1'b0;
      repeat (3) @(negedge clk);
      check("reset_hi", 64'(bus.o_HI), 64'd0);
      check("reset_lo", 64'(bus.o_LO), 64'd0);
      check("reset_busy", 64'(bus.o_Busy), 64'd0);
      check("reset_done", 64'(bus.o_Done), 64'd0);
      rst = 1'b0;

      run_op(MDU_MULT,  32'hFFFF_FFFE, 32'h0000_0003, 1'b0, 1'b0, "mult_neg");
      run_op(MDU_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0, "multu_max");
      run_op(MDU_DIV,   32'hFFFF_FFF9, 32'h0000_0002, 1'b0, 1'b0, "div_neg7_by2");
      run_op(MDU_DIVU,  32'h0000_0007, 32'h0000_0002, 1'b0, 1'b0, "divu_7_by2");
      run_op(MDU_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0, "div_overflow");
      run_op(MDU_DIVU,  32'h0000_1234, 32'h0000_0000, 1'b0, 1'b0, "divu_by0");
      run_op(MDU_DIV,   32'hFFFF_0000, 32'h0000_0000, 1'b0, 1'b0, "div_by0");
      run_op(MDU_DIV,   32'h0000_0064, 32'hFFFF_FFF9, 1'b0, 1'b0, "div_pos_by_neg");

      // MTLO in IDLE lands on the next edge; HI is left alone.
      prev_hi = bus.o_HI;
      @(negedge clk);
      bus.i_MTLOE = 1'b1;
      bus.i_SrcAE = 32'h0000_005A;
      @(negedge clk);
      bus.i_MTLOE = 1'b0;
      check("mtlo_idle_lo", 64'(bus.o_LO), 64'h5A);
      check("mtlo_idle_hi_kept", 64'(bus.o_HI), 64'(prev_hi));
      @(negedge clk);
      bus.i_MTHIE = 1'b1;
      bus.i_SrcAE = 32'h1357_9BDF;
      @(negedge clk);
      bus.i_MTHIE = 1'b0;
      check("mthi_idle_hi", 64'(bus.o_HI), 64'h1357_9BDF);

      run_op(MDU_MULTU, 32'h0000_1000, 32'h0000_0010, 1'b0, 1'b1, "mthi_while_busy");
      run_op(MDU_MULT,  32'h0BAD_F00D, 32'hFFFF_FFF0, 1'b1, 1'b0, "start_with_mt");

      for (int k = 0; k < 24; k++) begin
         rop = mdu_op_e'($urandom_range(0, 3));
         ra  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 200)) : 32'($urandom);
         case ($urandom_range(0, 5))
            0:       rb = 32'd0;
            1:       rb = 32'($urandom_range(1, 15));
            2:       rb = 32'hFFFF_FFFF;
            default: rb = $urandom;
         endcase
         run_op(rop, ra, rb, 1'b0, 1'b0, $sformatf("rand%0d_op%0d", k, rop));
      end

      // Asynchronous reset in the middle of an iterative divide.
      @(negedge clk);
      bus.i_StartE = 1'b1;
      bus.i_MduOpE = MDU_DIVU;
      bus.i_SrcAE  = 32'hDEAD_BEEF;
      bus.i_SrcBE  = 32'h0000_0013;
      @(negedge clk);
      bus.i_StartE = 1'b0;
      repeat (10) @(negedge clk);
      check("midcalc_busy_before_reset", 64'(bus.o_Busy), 64'd1);
      #2 rst = 1'b1;
      #1;
      check("midcalc_reset_busy", 64'(bus.o_Busy), 64'd0);
      check("midcalc_reset_hi", 64'(bus.o_HI), 64'd0);
      check("midcalc_reset_lo", 64'(bus.o_LO), 64'd0);
      @(negedge clk);
      rst = 1'b0;
      run_op(MDU_DIV, 32'hFFFF_FF00, 32'h0000_0007, 1'b0, 1'b0, "after_reset_div");
      run_op(MDU_MULT, 32'h7FFF_FFFF, 32'h8000_0000, 1'b0, 1'b0, "after_reset_mult");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
